// File: rtl/demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl
//
// Burst-granular round-robin dispatcher for a 1-to-4 demux datapath.
// One input valid/ready stream is steered to four consumer lanes, BURST
// accepted beats per grant. Disabled lanes are skipped. A single registered
// holding stage drives the shared out_data bus and a one-hot out_valid, so
// that each lane's backpressure is decoupled from the producer.
//
// Optional feature macro: DISPATCH_STATS_EN
//   defined   -> stat_cnt port present, one saturating delivered-beat
//                counter per lane
//   undefined -> no stat_cnt port, no counters
//
// Parameters
//   DW     data width
//   BURST  accepted beats per grant, 1..16
//   CNT_W  width of each statistics counter
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   en_mask    per-lane enable (bit i: lane i may be granted)
//   in_data    input beat
//   in_valid   input beat valid
//   in_ready   input beat accepted this cycle
//   out_data   held beat, common to all lanes
//   out_valid  one-hot, bit i: held beat belongs to lane i
//   out_ready  per-lane consumer ready
//   sel        currently granted lane
//   busy       granting, or a beat is still held
//   stat_cnt   per-lane delivered-beat counters, lane i at [i*CNT_W +: CNT_W]
//              (only with DISPATCH_STATS_EN)
//
// FSM states
//   state | meaning
//   IDLE  | no grant; pick the next enabled lane at or after ptr
//   GRANT | lane sel owns the input until BURST beats or its enable drops
// ---------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        en_mask,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW-1:0]     out_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [1:0]        sel,
    output logic              busy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [4*CNT_W-1:0] stat_cnt
`endif
);

    // Burst counter must hold values 0..BURST.
    localparam int BC_W = $clog2(BURST + 1);

    if (BURST < 1 || BURST > 16) begin : g_bad_burst
        $error("demux_dispatch_ctrl: BURST must be in 1..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("demux_dispatch_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [BC_W-1:0]   burst_cnt;
    logic              hold_valid;
    logic [1:0]        hold_ch;
    logic [DW-1:0]     hold_data;

    logic [1:0]        first_ch;
    logic              in_xfer;
    logic              out_xfer;
    logic              burst_last;

    // First enabled lane at or after ptr, wrapping modulo 4. The scan runs
    // from the farthest offset down so the nearest enabled lane wins.
    always_comb begin
        logic [1:0] cand;
        first_ch = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (en_mask[cand]) begin
                first_ch = cand;
            end
        end
    end

    // A slot opens when nothing is held or the held beat leaves this cycle,
    // which gives back-to-back loading with no bubble.
    assign in_ready   = (state == GRANT) & en_mask[sel] &
                        (~hold_valid | out_ready[hold_ch]);
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = hold_valid & out_ready[hold_ch];
    assign burst_last = (burst_cnt == BC_W'(BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_mask != 4'b0000) begin
                        sel       <= first_ch;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped enable truncates the burst; the pointer moves
                    // on exactly as for a completed burst.
                    if (!en_mask[sel]) begin
                        state <= IDLE;
                        ptr   <= sel + 2'd1;
                    end else if (in_xfer) begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                        if (burst_last) begin
                            state <= IDLE;
                            ptr   <= sel + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Holding stage. hold_ch is captured at load time, so a held beat always
    // goes to the lane that was granted when it was accepted, regardless of
    // later grant or enable changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_ch    <= 2'd0;
            hold_data  <= '0;
        end else if (in_xfer) begin
            hold_valid <= 1'b1;
            hold_ch    <= sel;
            hold_data  <= in_data;
        end else if (out_xfer) begin
            hold_valid <= 1'b0;
        end
    end

    assign out_data = hold_data;

    always_comb begin
        out_valid = 4'b0000;
        if (hold_valid) begin
            out_valid[hold_ch] = 1'b1;
        end
    end

    assign busy = (state == GRANT) | hold_valid;

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] cnt [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (out_xfer && (cnt[hold_ch] != {CNT_W{1'b1}})) begin
            cnt[hold_ch] <= cnt[hold_ch] + CNT_W'(1);
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            stat_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int CNT_W = 4;
    localparam int LOGD  = 64;

    logic            clk;
    logic            rst;
    logic [3:0]      en_mask;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [1:0]      sel;
    logic            busy;
`ifdef DISPATCH_STATS_EN
    logic [4*CNT_W-1:0] stat_cnt;
`endif

    demux_dispatch_ctrl #(.DW(DW), .BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_mask   (en_mask),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- delivery monitor ----------------
    logic [DW-1:0] dlog [4][LOGD];
    int            dcnt [4];
    bit            seen [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                dcnt[i] = 0;
                seen[i] = 0;
            end else begin
                if (out_valid[i] === 1'b1) seen[i] = 1;
                if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                    if (dcnt[i] < LOGD) dlog[i][dcnt[i]] = out_data;
                    dcnt[i]++;
                end
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    // Transaction-level view: "which lane owns the input and how many beats
    // it has taken", plus a one-entry buffer of (lane, data).
    bit            m_grant;
    int            m_sel, m_ptr, m_taken;
    bit            m_hv;
    int            m_hch;
    logic [DW-1:0] m_hdata;
    int            m_stat [4];
    bit            e_ir, e_busy, m_ix, m_ox, m_found;
    logic [3:0]    e_ov;

    always @(negedge clk) begin
        e_ov   = m_hv ? (4'b0001 << m_hch) : 4'b0000;
        e_ir   = m_grant && en_mask[m_sel] && (!m_hv || out_ready[m_hch]);
        e_busy = m_grant || m_hv;
        if (model_en) begin
            chk("model in_ready", 32'(in_ready), 32'(e_ir));
            chk("model out_valid", 32'(out_valid), 32'(e_ov));
            chk("model out_data", 32'(out_data), 32'(m_hdata));
            chk("model sel", 32'(sel), 32'(m_sel));
            chk("model busy", 32'(busy), 32'(e_busy));
`ifdef DISPATCH_STATS_EN
            for (int i = 0; i < 4; i++)
                chk($sformatf("model stat_cnt%0d", i), 32'(stat_cnt[i*CNT_W +: CNT_W]), 32'(m_stat[i]));
`endif
        end
        if (rst) begin
            m_grant = 0; m_sel = 0; m_ptr = 0; m_taken = 0;
            m_hv = 0; m_hch = 0; m_hdata = '0;
            for (int i = 0; i < 4; i++) m_stat[i] = 0;
        end else begin
            m_ix = in_valid && e_ir;
            m_ox = m_hv && out_ready[m_hch];
            if (!m_grant) begin
                if (en_mask != 4'b0000) begin
                    m_found = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!m_found && en_mask[(m_ptr + k) % 4]) begin
                            m_sel = (m_ptr + k) % 4;
                            m_found = 1;
                        end
                    end
                    m_grant = 1;
                    m_taken = 0;
                end
            end else if (!en_mask[m_sel]) begin
                m_ptr = (m_sel + 1) % 4;
                m_grant = 0;
            end else if (m_ix) begin
                m_taken++;
                if (m_taken == BURST) begin
                    m_ptr = (m_sel + 1) % 4;
                    m_grant = 0;
                end
            end
            if (m_ox && m_stat[m_hch] < (1 << CNT_W) - 1) m_stat[m_hch]++;
            if (m_ix) begin
                m_hv = 1; m_hch = m_sel; m_hdata = in_data;
            end else if (m_ox) begin
                m_hv = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1; en_mask = 0; in_valid = 0; in_data = 0; out_ready = 0;
        repeat (2) cycle();
        rst = 0;
    endtask

    task automatic send_beats(input int base, input int n, input int budget);
        int sent = 0;
        bit acc;
        in_valid = 1;
        for (int c = 0; c < budget && sent < n; c++) begin
            in_data = DW'(base + sent);
            #1;
            acc = in_ready;
            cycle();
            if (acc) sent++;
        end
        in_valid = 0;
        chk("send beats accepted before timeout", 32'(sent), 32'(n));
    endtask

    task automatic drain(input int n);
        in_valid = 0;
        out_ready = 4'b1111;
        repeat (n) cycle();
    endtask

    task automatic chk_seg(input int ch, input int idx, input int first, input int n);
        for (int k = 0; k < n; k++)
            chk($sformatf("ch%0d beat %0d", ch, idx + k), 32'(dlog[ch][idx + k]), 32'(first + k));
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0]    en;
        logic          iv;
        logic [DW-1:0] id;
        logic [3:0]    ordy;
        logic          e_ir;
        logic [3:0]    e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_sel;
        logic          e_busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Opening of the all-enabled round robin: IDLE, four ch0 beats,
        // one IDLE gap cycle, then ch1.
        tbl[0] = '{4'hF, 1'b1, 8'h00, 4'hF, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0};
        tbl[1] = '{4'hF, 1'b1, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b1};
        tbl[2] = '{4'hF, 1'b1, 8'h01, 4'hF, 1'b1, 4'b0001, 8'h00, 2'd0, 1'b1};
        tbl[3] = '{4'hF, 1'b1, 8'h02, 4'hF, 1'b1, 4'b0001, 8'h01, 2'd0, 1'b1};
        tbl[4] = '{4'hF, 1'b1, 8'h03, 4'hF, 1'b1, 4'b0001, 8'h02, 2'd0, 1'b1};
        tbl[5] = '{4'hF, 1'b1, 8'h04, 4'hF, 1'b0, 4'b0001, 8'h03, 2'd0, 1'b1};
        tbl[6] = '{4'hF, 1'b1, 8'h04, 4'hF, 1'b1, 4'b0000, 8'h03, 2'd1, 1'b1};
        tbl[7] = '{4'hF, 1'b1, 8'h05, 4'hF, 1'b1, 4'b0010, 8'h04, 2'd1, 1'b1};

        reset_dut();
        model_en = 1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset sel", 32'(sel), 32'h0);

        for (int i = 0; i < 8; i++) begin
            en_mask = tbl[i].en; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("vec%0d sel", i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            cycle();
        end

        // Round robin, 16 beats over all four lanes
        reset_dut();
        en_mask = 4'hF; out_ready = 4'hF;
        send_beats(0, 16, 200);
        drain(6);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("rr ch%0d count", ch), 32'(dcnt[ch]), 32'd4);
            chk_seg(ch, 0, ch * 4, 4);
        end

        // Skipping disabled lanes
        reset_dut();
        en_mask = 4'b0101; out_ready = 4'hF;
        send_beats(0, 16, 200);
        drain(6);
        chk("skip ch0 count", 32'(dcnt[0]), 32'd8);
        chk("skip ch2 count", 32'(dcnt[2]), 32'd8);
        chk_seg(0, 0, 0, 4);  chk_seg(0, 4, 8, 4);
        chk_seg(2, 0, 4, 4);  chk_seg(2, 4, 12, 4);
        chk("skip ch1 never valid", 32'(seen[1]), 32'd0);
        chk("skip ch3 never valid", 32'(seen[3]), 32'd0);

        // Backpressure mid-burst
        reset_dut();
        en_mask = 4'b0001; out_ready = 4'hF;
        send_beats(0, 2, 20);
        out_ready = 4'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall out_valid", 32'(out_valid), 32'b0001);
            chk("stall out_data", 32'(out_data), 32'h01);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 4'hF;
        send_beats(2, 6, 50);
        drain(6);
        chk("stall ch0 count", 32'(dcnt[0]), 32'd8);
        chk_seg(0, 0, 0, 8);

        // Truncation of a ch1 burst after its 2nd beat
        reset_dut();
        en_mask = 4'hF; out_ready = 4'hF;
        send_beats(0, 6, 50);
        en_mask = 4'b1101;
        #1;
        chk("trunc held out_valid", 32'(out_valid), 32'b0010);
        chk("trunc held out_data", 32'(out_data), 32'h05);
        chk("trunc in_ready", 32'(in_ready), 32'd0);
        send_beats(6, 4, 50);
        drain(6);
        chk("trunc ch0 count", 32'(dcnt[0]), 32'd4);
        chk("trunc ch1 count", 32'(dcnt[1]), 32'd2);
        chk("trunc ch2 count", 32'(dcnt[2]), 32'd4);
        chk_seg(1, 0, 4, 2);
        chk_seg(2, 0, 6, 4);

        // Reset with a beat held on ch2, then idle with nothing enabled
        reset_dut();
        en_mask = 4'b0100; out_ready = 4'hF;
        send_beats(8'h40, 1, 20);
        out_ready = 4'h0;
        rst = 1;
        cycle();
        chk("rst held out_valid", 32'(out_valid), 32'h0);
        chk("rst held sel", 32'(sel), 32'h0);
        chk("rst held busy", 32'(busy), 32'h0);
`ifdef DISPATCH_STATS_EN
        chk("rst held stat_cnt", 32'(stat_cnt), 32'h0);
`endif
        rst = 0; en_mask = 4'h0; in_valid = 1; in_data = 8'h77; out_ready = 4'hF;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("idle in_ready", 32'(in_ready), 32'd0);
            chk("idle busy", 32'(busy), 32'd0);
            cycle();
        end
        in_valid = 0;
        chk("idle no deliveries", 32'(dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3]), 32'd0);

`ifdef DISPATCH_STATS_EN
        // Saturation: 20 beats to ch0 only
        reset_dut();
        en_mask = 4'b0001; out_ready = 4'hF;
        send_beats(0, 20, 200);
        drain(6);
        chk("stats ch0 deliveries", 32'(dcnt[0]), 32'd20);
        chk("stats ch0 saturated", 32'(stat_cnt[3:0]), 32'hF);
        chk("stats others zero", 32'(stat_cnt[15:4]), 32'h0);
`endif

        // Randomised traffic against the reference model
        reset_dut();
        en_mask = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            rst       = (c == 1500);
            cycle();
        end
        rst = 0;
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Burst-granular round-robin dispatcher that sequences a 1-to-4 demultiplexer datapath.
- Accepts one valid/ready input stream and steers it to four output channels, BURST beats per grant, skipping disabled channels.
- A single registered holding stage provides the demux output and decouples per-channel backpressure.
- Sits between a shared producer and four consumer lanes; drives the select the demux tree would otherwise take from software.

## Interface
Parameters:
- DW, 8: data width.
- BURST, 4: accepted beats per grant; legal range 1..16.
- CNT_W, 16: width of each statistics counter; used only with DISPATCH_STATS_EN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  4  per-channel enable; bit i set means channel i may be granted.
- in_data  in  DW  input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DW  held beat, common to all channels.
- out_valid  out  4  one-hot; bit i set means the held beat is for channel i.
- out_ready  in  4  per-channel consumer ready.
- sel  out  2  currently granted channel.
- busy  out  1  high in GRANT or while a beat is held.
- stat_cnt  out  4*CNT_W  per-channel delivered-beat counters, channel i at bits [i*CNT_W +: CNT_W]; present only with DISPATCH_STATS_EN.

## Operation
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer on channel i: out_valid[i] & out_ready[i].
- Holding stage: hold_valid, hold_ch[1:0], hold_data.
  - out_data = hold_data.
  - out_valid = hold_valid ? onehot(hold_ch) : 0.
  - A beat is cleared on its output transfer. It is replaced in the same cycle if an input transfer also occurs.
- Pointer ptr[1:0]: round-robin start point.
- FSM states: IDLE and GRANT.
- IDLE:
  - in_ready = 0.
  - If en_mask == 0, stay in IDLE.
  - Otherwise, in one cycle, set sel to the first enabled channel at or after ptr (mod 4), clear burst_cnt, and go to GRANT.
- GRANT:
  - in_ready = en_mask[sel] & (~hold_valid | out_ready[hold_ch]).
  - On each input transfer: hold_data ← in_data, hold_ch ← sel, hold_valid ← 1, burst_cnt ← burst_cnt + 1.
  - When the transfer makes burst_cnt reach BURST: ptr ← sel + 1 (wraps 3→0), next state IDLE.
  - If en_mask[sel] is low: next state IDLE with ptr ← sel + 1. The burst is truncated and no further beats are accepted.
- A held beat always delivers to hold_ch, independent of later sel, en_mask or FSM changes.
- en_mask is sampled each cycle. A channel disabled while its beat is held still receives that beat.
- busy = (state == GRANT) | hold_valid.

## Timing
- Reset values:
  - state IDLE, ptr 0, sel 0, burst_cnt 0, hold_valid 0, hold_ch 0, hold_data 0.
  - Outputs: out_data 0, out_valid 0, in_ready 0, busy 0, stat_cnt 0.
- Reset mid-burst discards the held beat with no output transfer.
- Latency: a beat accepted at edge N is presented on out_valid/out_data from cycle N+1.
- Throughput: 1 beat/cycle within a grant while the target consumer is ready.
- Grant gap: exactly one IDLE cycle between consecutive grants, including a grant to the same channel when it is the only enabled one.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle: the new beat is loaded with no bubble.
  - Burst completion and en_mask drop in the same cycle: same next state (IDLE) and the same ptr update.
- Full backpressure: the held beat and out_valid stay stable until out_ready[hold_ch]. in_ready stays 0 meanwhile.

## Configuration
- DISPATCH_STATS_EN defined:
  - stat_cnt is present.
  - Counter i increments on each output transfer on channel i.
  - Counters saturate at all-ones and clear on rst.
- DISPATCH_STATS_EN undefined: stat_cnt and its counters are absent. All other behaviour is identical.

## Test plan
- Round robin: BURST=4, en_mask=4'b1111, in_valid=1, out_ready=4'b1111, 16 beats 0x00..0x0F → ch0 gets 0x00-0x03, ch1 0x04-0x07, ch2 0x08-0x0B, ch3 0x0C-0x0F. One idle cycle between bursts, 1-cycle latency.
- Skipping: en_mask=4'b0101 → grants alternate ch0, ch2. out_valid[1] and out_valid[3] never assert.
- Backpressure: out_ready[0]=0 for 5 cycles mid-burst → out_valid=4'b0001 and out_data held stable, in_ready=0. On release, the remaining beats complete with no loss or duplication.
- Truncation: clear en_mask[1] after the 2nd beat of a ch1 burst → held beat still delivered on ch1. The next grant goes to ch2 and ch1 receives exactly 2 beats.
- Reset and idle: assert rst with a beat held → next cycle out_valid=0, sel=0, stat_cnt=0. With en_mask=0: in_ready stays 0 and busy stays 0 indefinitely.
- Stats (DISPATCH_STATS_EN, CNT_W=4): 20 beats to ch0 only → stat_cnt[3:0] saturates at 4'hF and the other counters stay 0.
